// File: rtl/tt_pad_arbiter.sv
// rtl/tt_pad_arbiter.sv - round-robin time-sharing of one bidirectional pad with turnaround and pad config
// Optional: PAD_ARB_IDLE_PULL_EN pulls the pad low (PD=1, PU=0) while no owner drives it.
module tt_pad_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] gnt,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_wdata,
    output logic             cfg_err,
    input  logic             pad_Y,
    output logic             rd_data,
    output logic             pad_A,
    output logic             pad_OE,
    output logic             pad_IE,
    output logic             pad_SL,
    output logic             pad_CS,
    output logic             pad_PD,
    output logic             pad_PU
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [HW-1:0]   hold;
    logic [TW-1:0]   turn_cnt;
    logic [4:0]      cfg;
    logic [4:0]      cfg_next;
    logic            cfg_clash;
    logic            sync1;
    logic            sync2;

    logic [N_REQ-1:0] cand;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    scan_idx;

    // Candidates never include the current owner, so preemption always moves the pad on.
    always_comb begin
        cand     = (state == S_IDLE) ? req : (req & ~(N_REQ'(1) << owner));
        pick_any = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = IW'((int'(rr_ptr) + i) % N_REQ);
            if (cand[scan_idx]) begin
                pick_any = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // {CS,SL,PU,PD,IE}; a PU+PD clash stores both pulls off.
    always_comb begin
        cfg_clash = cfg_we && cfg_wdata[2] && cfg_wdata[1];
        cfg_next  = cfg;
        if (cfg_we) begin
            cfg_next = cfg_clash ? (cfg_wdata & 5'b11001) : cfg_wdata;
        end
    end

    assign rd_data = sync2 & cfg[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold     <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            cfg      <= '0;
            cfg_err  <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            pad_A    <= 1'b0;
            pad_OE   <= 1'b0;
            pad_IE   <= 1'b0;
            pad_SL   <= 1'b0;
            pad_CS   <= 1'b0;
            pad_PD   <= 1'b0;
            pad_PU   <= 1'b0;
        end else begin
            cfg     <= cfg_next;
            cfg_err <= cfg_err | cfg_clash;
            sync1   <= pad_Y;
            sync2   <= sync1;
            pad_IE  <= cfg_next[0];
            pad_SL  <= cfg_next[3];
            pad_CS  <= cfg_next[4];
            pad_OE  <= (state == S_OWN);
            pad_A   <= (state == S_OWN) && req_data[owner];
`ifdef PAD_ARB_IDLE_PULL_EN
            pad_PU  <= (state == S_OWN) ? cfg_next[2] : 1'b0;
            pad_PD  <= (state == S_OWN) ? cfg_next[1] : 1'b1;
`else
            pad_PU  <= cfg_next[2];
            pad_PD  <= cfg_next[1];
`endif

            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        turn_cnt <= '0;
                        state    <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (turn_cnt == TW'(TURN_CYCLES - 1)) begin
                        if (req[owner]) begin
                            state  <= S_OWN;
                            gnt    <= N_REQ'(1) << owner;
                            rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                            hold   <= HW'(1);
                        end else if (pick_any) begin
                            owner    <= pick_idx;
                            turn_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                S_OWN: begin
                    if (!req[owner] || (hold == HW'(HOLD_CYCLES) && pick_any)) begin
                        gnt <= '0;
                        if (pick_any) begin
                            owner    <= pick_idx;
                            turn_cnt <= '0;
                            state    <= S_TURN;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (hold != HW'(HOLD_CYCLES)) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
